// File: rtl/m_fetch_predictor_pkg.sv
// Shared definitions for the fetch/predict stage: RV32I encodings, the BTB entry
// layout and the 2-bit saturating counter helpers.
package m_fetch_predictor_pkg;

  localparam logic [31:0] NOP_INSTR_C  = 32'h0000_0013;
  localparam logic [31:0] HALT_INSTR_C = 32'h000f_0033;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Tag storage is sized for the widest legal tag; narrower tags are zero-extended.
  localparam int BTB_TAG_MAX = 30;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [31:0]            target;
    logic [1:0]             ctr;
  } btb_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

endpackage

// File: rtl/m_fetch_predictor_btb.sv
// Direct-mapped branch target buffer: one combinational lookup port and one
// training port that writes at the clock edge (lookup sees the pre-update entry).
module m_btb
  import m_fetch_predictor_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] lkp_pc,
  output logic        lkp_taken,
  output logic [31:0] lkp_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int N = 1 << IDX_W;

  btb_entry_t             btb_r [N];
  logic [IDX_W-1:0]       lkp_idx_s;
  logic [IDX_W-1:0]       upd_idx_s;
  logic [BTB_TAG_MAX-1:0] lkp_tag_s;
  logic [BTB_TAG_MAX-1:0] upd_tag_s;
  btb_entry_t             lkp_ent_s;
  btb_entry_t             upd_ent_s;
  btb_entry_t             upd_new_s;
  logic                   upd_hit_s;
  logic                   upd_we_s;
  logic                   unused_s;

  assign unused_s = ^{lkp_pc[31:TAG_W+IDX_W+2], lkp_pc[1:0],
                      upd_pc[31:TAG_W+IDX_W+2], upd_pc[1:0]};

  // Lookup: predict taken only on a valid tag hit with the counter in a taken state
  always_comb begin
    lkp_idx_s  = lkp_pc[IDX_W+1:2];
    lkp_tag_s  = BTB_TAG_MAX'(lkp_pc[TAG_W+IDX_W+1:IDX_W+2]);
    lkp_ent_s  = btb_r[lkp_idx_s];
    lkp_taken  = lkp_ent_s.valid && (lkp_ent_s.tag == lkp_tag_s) && lkp_ent_s.ctr[1];
    if (lkp_taken) begin
      lkp_target = lkp_ent_s.target;
    end else begin
      lkp_target = 32'h0000_0000;
    end
  end

  // Training: hits move the counter, taken misses allocate, not-taken misses are ignored
  always_comb begin
    upd_idx_s = upd_pc[IDX_W+1:2];
    upd_tag_s = BTB_TAG_MAX'(upd_pc[TAG_W+IDX_W+1:IDX_W+2]);
    upd_ent_s = btb_r[upd_idx_s];
    upd_hit_s = upd_ent_s.valid && (upd_ent_s.tag == upd_tag_s);
    upd_new_s = upd_ent_s;
    upd_we_s  = 1'b0;
    if (upd_valid && upd_hit_s) begin
      upd_we_s = 1'b1;
      if (upd_taken) begin
        upd_new_s.ctr    = sat_inc(upd_ent_s.ctr);
        upd_new_s.target = upd_target;
      end else begin
        upd_new_s.ctr = sat_dec(upd_ent_s.ctr);
      end
    end else if (upd_valid && upd_taken) begin
      upd_we_s         = 1'b1;
      upd_new_s.valid  = 1'b1;
      upd_new_s.tag    = upd_tag_s;
      upd_new_s.target = upd_target;
      upd_new_s.ctr    = 2'b10;
    end else begin
      upd_we_s = 1'b0;
    end
  end

  // Entry storage with weakly-not-taken counters out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        btb_r[i] <= '{valid: 1'b0, tag: '0, target: 32'h0000_0000, ctr: 2'b01};
      end
    end else if (ce && upd_we_s) begin
      btb_r[upd_idx_s] <= upd_new_s;
    end
  end

endmodule

// File: rtl/m_fetch_predictor.sv
// Instruction-fetch stage: drives the synchronous imem, predicts the next PC from
// the BTB and accepts redirects/training from the branch-resolving stage.
module m_fetch_predictor
  import m_fetch_predictor_pkg::*;
#(
  parameter int          BTB_IDX_W  = 4,
  parameter int          BTB_TAG_W  = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_C,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [11:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_target,
  output logic        halted
);

  logic [31:0] pc_r;
  logic        valid_r;
  logic        halted_r;
  logic [31:0] next_pc_s;
  logic        valid_nxt_s;
  logic        halted_nxt_s;
  logic        pred_taken_s;
  logic [31:0] pred_target_s;

  m_btb #(
    .IDX_W (BTB_IDX_W),
    .TAG_W (BTB_TAG_W)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .lkp_pc     (pc_r),
    .lkp_taken  (pred_taken_s),
    .lkp_target (pred_target_s),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  // Next-address selection; imem is addressed with next so data lines up with pc_r
  always_comb begin
    next_pc_s    = pc_r;
    valid_nxt_s  = valid_r;
    halted_nxt_s = halted_r;
    if (rst) begin
      next_pc_s    = RESET_PC;
      valid_nxt_s  = 1'b0;
      halted_nxt_s = 1'b0;
    end else if (!ce) begin
      next_pc_s = pc_r;
    end else if (redirect_valid) begin
      next_pc_s    = redirect_pc;
      valid_nxt_s  = 1'b1;
      halted_nxt_s = 1'b0;
    end else if (halted_r || stall) begin
      next_pc_s = pc_r;
    end else if (!valid_r) begin
      valid_nxt_s = 1'b1;
    end else if (imem_data == HALT_INSTR) begin
      halted_nxt_s = 1'b1;
    end else if (pred_taken_s) begin
      next_pc_s = pred_target_s;
    end else begin
      next_pc_s = pc_r + 32'd4;
    end
  end

  assign imem_addr = next_pc_s[13:2];
  assign halted    = halted_r;

  // Fetch state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else if (ce) begin
      pc_r     <= next_pc_s;
      valid_r  <= valid_nxt_s;
      halted_r <= halted_nxt_s;
    end
  end

  // Output muxing: a halted fetch keeps re-reading HALT but never re-presents it
  always_comb begin
    out_valid       = valid_r & ~halted_r & ~redirect_valid;
    out_pc          = 32'h0000_0000;
    out_instr       = NOP_INSTR;
    out_pred_taken  = 1'b0;
    out_pred_target = 32'h0000_0000;
    if (out_valid) begin
      out_pc          = pc_r;
      out_instr       = imem_data;
      out_pred_taken  = pred_taken_s;
      out_pred_target = pred_target_s;
    end else begin
      out_pc = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_m_fetch_predictor.sv
// Scoreboard bench for m_fetch_predictor: expected fetches are queued as stimulus
// is driven and compared whenever ID would accept an instruction.
module tb_m_fetch_predictor;
  import m_fetch_predictor_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ce, stall, redirect_valid, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target, imem_data;
  logic [11:0] imem_addr;
  logic        out_valid, out_pred_taken, halted;
  logic [31:0] out_pc, out_instr, out_pred_target;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] mem [4096];
  int          n_checks = 0;
  int          n_fail   = 0;

  m_fetch_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .ce              (ce),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_pred_taken  (out_pred_taken),
    .out_pred_target (out_pred_target),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory
  always @(posedge clk) imem_data <= mem[imem_addr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    exp_t e;
    e.pc = pc; e.taken = tk; e.tgt = tgt;
    sb_q.push_back(e);
  endtask

  task automatic push_run(input logic [31:0] from, input logic [31:0] to);
    for (logic [31:0] a = from; a <= to; a += 32'd4) push_exp(a, 1'b0, 32'h0);
  endtask

  task automatic wait_pc(input logic [31:0] target);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(out_valid && out_pc == target) && n < 40);
    if (!(out_valid && out_pc == target)) check_val("wait_pc", out_pc, target);
  endtask

  task automatic check_bubble(input string tag);
    check_val({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    check_val({tag, "_pc"}, out_pc, 32'h0);
    check_val({tag, "_instr"}, out_instr, NOP_INSTR_C);
  endtask

  // an instruction is consumed whenever it is valid and ID is not stalling
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && !stall) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check_val("out_pc", out_pc, e.pc);
        check_val("out_instr", out_instr, mem[e.pc[13:2]]);
        check_val("pred_taken", {31'b0, out_pred_taken}, {31'b0, e.taken});
        check_val("pred_target", out_pred_target, e.tgt);
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0000_0013 | (i << 7);
    mem[12] = HALT_INSTR_C;
    rst = 1'b1; ce = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;

    // reset and first valid fetch
    repeat (3) step();
    check_val("rst_valid", {31'b0, out_valid}, 32'd0);
    check_val("rst_halted", {31'b0, halted}, 32'd0);
    check_val("rst_imem_addr", {20'b0, imem_addr}, 32'h0);
    rst = 1'b0;
    push_run(32'h0, 32'h10);
    check_bubble("first_cycle");
    step();
    check_val("second_cycle_valid", {31'b0, out_valid}, 32'd1);

    // stall holds 0x10 for three cycles
    wait_pc(32'h10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_val("stall_pc", out_pc, 32'h10);
      check_val("stall_instr", out_instr, mem[4]);
      step();
    end
    stall = 1'b0;

    // train 0x20 taken -> 0x8
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_target = 32'h8;
    push_run(32'h14, 32'h1c);
    push_exp(32'h20, 1'b1, 32'h8);
    push_exp(32'h8, 1'b0, 32'h0);
    step();
    upd_valid = 1'b0;
    wait_pc(32'h20);
    wait_pc(32'h8);

    // two not-taken updates: counter 10 -> 01 -> 00
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b0;
    push_run(32'h0c, 32'h30);
    step();
    step();
    upd_valid = 1'b0;

    // HALT at 0x30 presented once, then held invisible
    n = 0;
    do begin step(); n++; end while (!halted && n < 40);
    check_val("halted", {31'b0, halted}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_target = 32'h8;
      check_bubble("halt_hold");
      step();
    end
    upd_valid = 1'b0;

    // redirect to 0 clears halt; saturated counter predicts taken at 0x20
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    check_bubble("redir_bubble");
    push_run(32'h0, 32'h1c);
    push_exp(32'h20, 1'b1, 32'h8);
    push_exp(32'h8, 1'b0, 32'h0);
    step();
    redirect_valid = 1'b0;
    check_val("halt_clear", {31'b0, halted}, 32'd0);
    wait_pc(32'h20);
    wait_pc(32'h8);
    push_exp(32'h0c, 1'b0, 32'h0);

    // redirect to 0x40 while stalled
    wait_pc(32'h10);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    check_bubble("redir_stall");
    push_run(32'h40, 32'h4c);
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin step(); n++; end
    stall = 1'b1;
    check_val("sb_drain", sb_q.size(), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
